// File: rtl/counter_share_arbiter_pkg.sv
// Shared types and constants for the counter_share_arbiter block.
// The optional COUNT_SAT_EN macro (saturating count) is consumed in step_counter.
package counter_arb_pkg;

  localparam int WIDTH_DEF = 4;
  localparam int LEN_W_DEF = 3;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/counter_share_arbiter_step_counter.sv
// step_counter: WIDTH-bit up/down register advancing one unit per enabled cycle.
// Build option COUNT_SAT_EN: when defined the count clamps at 0 and all-ones,
// otherwise it wraps modulo 2^WIDTH. Steps at a clamp still consume the cycle.
module step_counter
  import counter_arb_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic             up_i,
  output logic [WIDTH-1:0] count_o
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
  localparam logic [WIDTH-1:0] MAX = '1;

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // Next count: hold, or one step in the latched direction (wrap or clamp).
  always_comb begin
    count_d = count_q;
    if (en_i) begin
      if (up_i == DIR_UP) begin
`ifdef COUNT_SAT_EN
        if (count_q != MAX) count_d = count_q + ONE;
`else
        count_d = count_q + ONE;
`endif
      end else begin
`ifdef COUNT_SAT_EN
        if (count_q != '0) count_d = count_q - ONE;
`else
        count_d = count_q - ONE;
`endif
      end
    end
  end

  // Count register, cleared immediately by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign count_o = count_q;

endmodule

// File: rtl/counter_share_arbiter.sv
// counter_share_arbiter: two requesters share one up/down step counter.
// A grant runs a whole burst of len steps; round-robin between requesters.
// Handshake: req is a level sampled only in IDLE; gnt is held from the
// cycle after the sampling edge through the single DONE cycle, in which
// done[owner] pulses. dir/len are latched at grant and ignored afterwards.
// Optional build macro COUNT_SAT_EN selects saturating count (see step_counter).
module counter_share_arbiter
  import counter_arb_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int LEN_W = LEN_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       req,
  input  logic [1:0]       dir,
  input  logic [LEN_W-1:0] len0,
  input  logic [LEN_W-1:0] len1,
  output logic [1:0]       gnt,
  output logic [1:0]       done,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             owner
);

  localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

  state_e           state_q, state_d;
  logic [1:0]       gnt_q, gnt_d;
  logic             owner_q, owner_d;
  logic             dir_q, dir_d;
  logic [LEN_W-1:0] rem_q, rem_d;

  logic             win;
  logic [LEN_W-1:0] win_len;
  logic             step_en;

  // Round-robin pick: on a tie the requester that did not own last wins.
  always_comb begin
    if (req == 2'b11) win = ~owner_q;
    else              win = req[1];
    win_len = win ? len1 : len0;
  end

  // FSM next-state, grant, owner and remaining-step bookkeeping.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    owner_d = owner_q;
    dir_d   = dir_q;
    rem_d   = rem_q;
    unique case (state_q)
      ST_IDLE: begin
        if (req != 2'b00) begin
          gnt_d   = win ? 2'b10 : 2'b01;
          owner_d = win;
          dir_d   = dir[win];
          rem_d   = win_len;
          state_d = (win_len == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        rem_d = rem_q - LEN_ONE;
        if (rem_q == LEN_ONE) state_d = ST_DONE;
      end
      ST_DONE: begin
        gnt_d   = 2'b00;
        state_d = ST_IDLE;
      end
      default: begin
        gnt_d   = 2'b00;
        state_d = ST_IDLE;
      end
    endcase
  end

  // Arbiter state registers; owner resets to 1 so requester 0 wins first.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      gnt_q   <= 2'b00;
      owner_q <= 1'b1;
      dir_q   <= DIR_DOWN;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      owner_q <= owner_d;
      dir_q   <= dir_d;
      rem_q   <= rem_d;
    end
  end

  assign step_en = (state_q == ST_RUN);

  step_counter #(.WIDTH(WIDTH)) u_step_counter (
    .clk     (clk),
    .rst     (reset),
    .en_i    (step_en),
    .up_i    (dir_q),
    .count_o (count)
  );

  assign gnt   = gnt_q;
  assign owner = owner_q;
  assign busy  = (state_q != ST_IDLE);
  assign done  = (state_q == ST_DONE) ? (owner_q ? 2'b10 : 2'b01) : 2'b00;

endmodule

// File: tb/tb_counter_share_arbiter.sv
// Testbench for counter_share_arbiter (WIDTH=4, LEN_W=3).
// Driver applies inputs on the falling edge and advances a burst-level
// reference model; the monitor samples just after the rising edge.
module tb_counter_share_arbiter;

  localparam int WIDTH = 4;
  localparam int LEN_W = 3;
  localparam int MAXV  = (1 << WIDTH) - 1;
  localparam int EW    = 2 + WIDTH;

  // ---------------- clock / reset ----------------
  logic             clk = 1'b0;
  logic             reset;
  logic [1:0]       req;
  logic [1:0]       dir;
  logic [LEN_W-1:0] len0;
  logic [LEN_W-1:0] len1;
  logic [1:0]       gnt;
  logic [1:0]       done;
  logic [WIDTH-1:0] count;
  logic             busy;
  logic             owner;

  always #5 clk = ~clk;

  counter_share_arbiter #(.WIDTH(WIDTH), .LEN_W(LEN_W)) dut (
    .clk   (clk),
    .reset (reset),
    .req   (req),
    .dir   (dir),
    .len0  (len0),
    .len1  (len1),
    .gnt   (gnt),
    .done  (done),
    .count (count),
    .busy  (busy),
    .owner (owner)
  );

  // ---------------- scoreboard ----------------
  logic [EW-1:0] exp_q[$];   // {done one-hot, count at done}
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // A burst granted at edge t0 with start value c and length n shows count
  // step(c,k) k edges later (k<=n), pulses done when k==n, and frees the
  // counter one edge after that.
  function automatic int step_val(input int c, input bit up, input int k);
`ifdef COUNT_SAT_EN
    if (up) return (c + k > MAXV) ? MAXV : c + k;
    else    return (c - k < 0) ? 0 : c - k;
`else
    if (up) return (c + k) % (MAXV + 1);
    else    return ((c - k) % (MAXV + 1) + MAXV + 1) % (MAXV + 1);
`endif
  endfunction

  bit   in_burst = 0;
  int   m_t = 0, m_len = 0, m_start = 0, m_count = 0;
  bit   m_up = 0, m_owner = 1;
  logic [1:0] m_oh = 2'b00;

  // Expected outputs just after the upcoming rising edge.
  int   e_count = 0;
  bit   e_busy = 0, e_owner = 1;
  logic [1:0] e_gnt = 2'b00, e_done = 2'b00;

  task automatic model_edge();
    bit w;
    int k;
    if (reset) begin
      in_burst = 0; m_count = 0; m_owner = 1; m_oh = 2'b00;
      exp_q.delete();
    end else if (in_burst) begin
      m_t++;
      if (m_t > m_len) begin
        in_burst = 0;
        m_count  = step_val(m_start, m_up, m_len);
      end
    end else if (req != 2'b00) begin
      w        = (req == 2'b11) ? !m_owner : req[1];
      m_owner  = w;
      m_oh     = w ? 2'b10 : 2'b01;
      m_len    = w ? int'(len1) : int'(len0);
      m_up     = dir[w];
      m_start  = m_count;
      m_t      = 0;
      in_burst = 1;
      exp_q.push_back({m_oh, WIDTH'(step_val(m_start, m_up, m_len))});
    end
    k       = (m_t < m_len) ? m_t : m_len;
    e_busy  = in_burst;
    e_gnt   = in_burst ? m_oh : 2'b00;
    e_done  = (in_burst && m_t == m_len) ? m_oh : 2'b00;
    e_count = in_burst ? step_val(m_start, m_up, k) : m_count;
    e_owner = m_owner;
  endtask

  // ---------------- driver ----------------
  task automatic drive(input logic r, input logic [1:0] q, input logic [1:0] d,
                       input logic [LEN_W-1:0] a, input logic [LEN_W-1:0] b);
    @(negedge clk);
    reset = r; req = q; dir = d; len0 = a; len1 = b;
    model_edge();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 2'b00, 2'b00, '0, '0);
  endtask

  task automatic do_reset();
    drive(1'b1, 2'b00, 2'b00, '0, '0);
    drive(1'b1, 2'b00, 2'b00, '0, '0);
    idle(1);
  endtask

  // ---------------- monitor ----------------
  initial begin
    logic [EW-1:0] e;
    forever begin
      @(posedge clk);
      #1;
      chk("busy",  int'(busy),  int'(e_busy));
      chk("gnt",   int'(gnt),   int'(e_gnt));
      chk("done",  int'(done),  int'(e_done));
      chk("count", int'(count), e_count);
      chk("owner", int'(owner), int'(e_owner));
      if (done != 2'b00) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_done", int'(done), 0);
        end else begin
          e = exp_q.pop_front();
          chk("sb_done_owner", int'(done),  int'(e[EW-1 -: 2]));
          chk("sb_done_count", int'(count), int'(e[WIDTH-1:0]));
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1; req = 2'b00; dir = 2'b00; len0 = '0; len1 = '0;
    model_edge();

    // single burst up, len 3
    do_reset();
    drive(1'b0, 2'b01, 2'b01, 3'd3, 3'd0);
    idle(6);

    // simultaneous requests held: 0,1,0 with opposite directions
    do_reset();
    for (int i = 0; i < 11; i++) drive(1'b0, 2'b11, 2'b01, 3'd2, 3'd2);
    idle(5);

    // wrap (or clamp) downward from 0
    do_reset();
    drive(1'b0, 2'b10, 2'b00, 3'd0, 3'd2);
    idle(5);

    // wrap (or clamp) upward past all-ones: 7 + 7 + 2 steps up
    do_reset();
    drive(1'b0, 2'b01, 2'b01, 3'd7, 3'd0); idle(9);
    drive(1'b0, 2'b01, 2'b01, 3'd7, 3'd0); idle(9);
    drive(1'b0, 2'b10, 2'b10, 3'd0, 3'd2); idle(4);

    // zero-length burst
    do_reset();
    drive(1'b0, 2'b01, 2'b01, 3'd0, 3'd0);
    idle(4);

    // mid-burst disturbance: drop req, flip dir
    do_reset();
    drive(1'b0, 2'b01, 2'b01, 3'd7, 3'd0);
    drive(1'b0, 2'b01, 2'b01, 3'd7, 3'd0);
    for (int i = 0; i < 10; i++) drive(1'b0, 2'b00, 2'b00, 3'd1, 3'd5);

    // reset mid-burst, then a short burst
    do_reset();
    drive(1'b0, 2'b01, 2'b01, 3'd5, 3'd0);
    idle(2);
    drive(1'b1, 2'b00, 2'b00, '0, '0);
    drive(1'b0, 2'b01, 2'b01, 3'd1, 3'd0);
    idle(4);

    // randomized traffic with occasional resets
    for (int i = 0; i < 600; i++) begin
      drive(($urandom_range(0, 149) == 0) ? 1'b1 : 1'b0,
            2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
            3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
    end

    // drain: every granted burst must have produced its done
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) idle(1);
    idle(2);
    chk("drain_queue_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
